// File: rtl/mtr_spd_calc.sv
// Sums the PID terms, ramps forward speed and produces saturated left/right motor commands.
// Optional steering dead-zone enabled by defining MTR_SPD_DZ_EN.
module mtr_spd_calc #(
   parameter int unsigned RAMP_STEP = 4,
   parameter int unsigned DZ_THRESH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pid_vld,
   input  logic               moving,
   input  logic signed [13:0] P_term,
   input  logic signed [8:0]  I_term,
   input  logic signed [12:0] D_term,
   input  logic        [9:0]  frwrd_cmd,
   output logic signed [10:0] lft_spd,
   output logic signed [10:0] rght_spd,
   output logic               spd_vld,
   output logic        [9:0]  frwrd
);

`ifdef MTR_SPD_DZ_EN
   localparam bit DzEn = 1'b1;
`else
   localparam bit DzEn = 1'b0;
`endif

   localparam logic [9:0]  Step  = 10'(RAMP_STEP);
   localparam logic [9:0]  Step2 = 10'(2 * RAMP_STEP);
   localparam logic [11:0] DzLim = 12'(DZ_THRESH);

   logic signed [14:0] pid_sum_q, pid_sum_d;
   logic               moving_q;
   logic               v1_q;
   logic        [9:0]  frwrd_q, frwrd_d;
   logic signed [10:0] lft_q, rght_q, lft_d, rght_d;
   logic               spd_vld_q;

   logic signed [11:0] pid, pid_adj;
   logic        [11:0] pid_abs;
   logic signed [12:0] frwrd_s, pid_x, lft_raw, rght_raw;
   logic               unused_sum_lsb;

   function automatic logic signed [10:0] sat11(input logic signed [12:0] v);
      if (v > 13'sd1023)
         return 11'sd1023;
      else if (v < -13'sd1024)
         return -11'sd1024;
      else
         return v[10:0];
   endfunction

   always_comb begin
      pid_sum_d = {P_term[13], P_term}
                + {{6{I_term[8]}}, I_term}
                + {{2{D_term[12]}}, D_term};
   end

   // Ramp toward the target, clamping at the target so it never overshoots
   always_comb begin
      frwrd_d = frwrd_q;
      if (moving) begin
         if (frwrd_q < frwrd_cmd) begin
            if ((frwrd_cmd - frwrd_q) > Step)
               frwrd_d = frwrd_q + Step;
            else
               frwrd_d = frwrd_cmd;
         end else if (frwrd_q > frwrd_cmd) begin
            if ((frwrd_q - frwrd_cmd) > Step)
               frwrd_d = frwrd_q - Step;
            else
               frwrd_d = frwrd_cmd;
         end
      end else begin
         if (frwrd_q > Step2)
            frwrd_d = frwrd_q - Step2;
         else
            frwrd_d = 10'd0;
      end
   end

   // Dropping the low three bits of a signed value is an arithmetic shift with floor rounding
   assign pid            = pid_sum_q[14:3];
   assign unused_sum_lsb = ^pid_sum_q[2:0];

   always_comb begin
      pid_abs = pid[11] ? 12'(-pid) : 12'(pid);
      pid_adj = pid;
      if (DzEn && (pid_abs < DzLim))
         pid_adj = 12'sd0;
      frwrd_s  = {3'b000, frwrd_q};
      pid_x    = {pid_adj[11], pid_adj};
      lft_raw  = frwrd_s + pid_x;
      rght_raw = frwrd_s - pid_x;
      lft_d    = lft_q;
      rght_d   = rght_q;
      if (v1_q) begin
         if (moving_q) begin
            lft_d  = sat11(lft_raw);
            rght_d = sat11(rght_raw);
         end else begin
            lft_d  = 11'sd0;
            rght_d = 11'sd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pid_sum_q <= '0;
         moving_q  <= 1'b0;
         v1_q      <= 1'b0;
         frwrd_q   <= '0;
         lft_q     <= '0;
         rght_q    <= '0;
         spd_vld_q <= 1'b0;
      end else begin
         v1_q      <= pid_vld;
         spd_vld_q <= v1_q;
         lft_q     <= lft_d;
         rght_q    <= rght_d;
         if (pid_vld) begin
            pid_sum_q <= pid_sum_d;
            moving_q  <= moving;
            frwrd_q   <= frwrd_d;
         end
      end
   end

   assign lft_spd  = lft_q;
   assign rght_spd = rght_q;
   assign spd_vld  = spd_vld_q;
   assign frwrd    = frwrd_q;

endmodule

// File: tb/tb_mtr_spd_calc.sv
// Directed self-checking bench for mtr_spd_calc (default RAMP_STEP=4, DZ_THRESH=8).
module tb_mtr_spd_calc;

   logic               clk = 1'b0;
   logic               rst;
   logic               pid_vld;
   logic               moving;
   logic signed [13:0] P_term;
   logic signed [8:0]  I_term;
   logic signed [12:0] D_term;
   logic        [9:0]  frwrd_cmd;
   logic signed [10:0] lft_spd;
   logic signed [10:0] rght_spd;
   logic               spd_vld;
   logic        [9:0]  frwrd;

   int n_checks = 0;
   int n_errors = 0;

   mtr_spd_calc dut (
      .clk       (clk),
      .rst       (rst),
      .pid_vld   (pid_vld),
      .moving    (moving),
      .P_term    (P_term),
      .I_term    (I_term),
      .D_term    (D_term),
      .frwrd_cmd (frwrd_cmd),
      .lft_spd   (lft_spd),
      .rght_spd  (rght_spd),
      .spd_vld   (spd_vld),
      .frwrd     (frwrd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_terms(input int p, input int i, input int d);
      P_term = 14'(p);
      I_term = 9'(i);
      D_term = 13'(d);
   endtask

   // Streaming vectors: terms and expected outputs (frwrd ramps 4,8,8,8,8 with cmd=8)
   int sp[5] = '{800, -160, 0, 0, 13};
   int si[5] = '{0, 0, -256, 0, 3};
   int sd[5] = '{0, 0, 0, -4096, 0};
   int sl[5] = '{104, -12, -24, -504, 10};
   int sr[5] = '{-96, 28, 40, 520, 6};

   initial begin
      rst = 1'b1; pid_vld = 1'b1; moving = 1'b1; frwrd_cmd = 10'd100;
      set_terms(500, 10, 10);
      tick();
      tick();
      rst = 1'b0; pid_vld = 1'b0;
      check("rst_lft", lft_spd, 0);
      check("rst_rght", rght_spd, 0);
      check("rst_frwrd", frwrd, 0);
      check("rst_vld", spd_vld, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_idle_vld", spd_vld, 0);
      end

      // Basic
      frwrd_cmd = 10'h100; moving = 1'b1; set_terms(100, 20, -40); pid_vld = 1'b1;
      tick();
      pid_vld = 1'b0;
      check("basic_frwrd", frwrd, 4);
      check("basic_vld_early", spd_vld, 0);
      tick();
      check("basic_vld", spd_vld, 1);
      check("basic_lft", lft_spd, 14);
      check("basic_rght", rght_spd, -6);
      tick();
      check("basic_vld_drop", spd_vld, 0);
      check("basic_hold_lft", lft_spd, 14);

      // Saturation (frwrd ramps 4 -> 0)
      frwrd_cmd = 10'd0; set_terms(8191, 255, 4095); pid_vld = 1'b1;
      tick();
      pid_vld = 1'b0;
      check("sat_frwrd", frwrd, 0);
      tick();
      check("sat_vld", spd_vld, 1);
      check("sat_lft", lft_spd, 1023);
      check("sat_rght", rght_spd, -1024);

      // Ramp up, then ramp down with moving dropped
      tick();
      frwrd_cmd = 10'd10; set_terms(0, 0, 0); pid_vld = 1'b1;
      tick(); check("ramp_f1", frwrd, 4);
      tick(); check("ramp_f2", frwrd, 8);  check("ramp_l1", lft_spd, 4);
      tick(); check("ramp_f3", frwrd, 10); check("ramp_l2", lft_spd, 8);
      tick(); check("ramp_f4", frwrd, 10); check("ramp_l3", lft_spd, 10);
      moving = 1'b0;
      tick(); check("ramp_d1", frwrd, 2);  check("ramp_l4", lft_spd, 10);
      tick(); check("ramp_d2", frwrd, 0);
      check("ramp_stop_lft", lft_spd, 0);
      check("ramp_stop_rght", rght_spd, 0);
      pid_vld = 1'b0;
      tick(); check("ramp_last_vld", spd_vld, 1); check("ramp_last_rght", rght_spd, 0);
      tick(); check("ramp_idle_vld", spd_vld, 0);

      // Negative rounding: -9 >>> 3 = -2
      moving = 1'b1; frwrd_cmd = 10'd0; set_terms(-9, 0, 0); pid_vld = 1'b1;
      tick();
      pid_vld = 1'b0;
      tick();
      check("neg_vld", spd_vld, 1);
`ifdef MTR_SPD_DZ_EN
      check("neg_lft", lft_spd, 0);
      check("neg_rght", rght_spd, 0);
`else
      check("neg_lft", lft_spd, -2);
      check("neg_rght", rght_spd, 2);
`endif
      tick();

      // Streaming: five back-to-back updates
      frwrd_cmd = 10'd8;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            set_terms(sp[i], si[i], sd[i]);
            pid_vld = 1'b1;
         end else begin
            pid_vld = 1'b0;
         end
         tick();
         if (i >= 1) begin
            check("strm_vld", spd_vld, 1);
            check("strm_lft", lft_spd, sl[i-1]);
            check("strm_rght", rght_spd, sr[i-1]);
         end
      end
      tick();
      check("strm_end_vld", spd_vld, 0);

      // Reset while an update is in flight
      set_terms(400, 0, 0); pid_vld = 1'b1;
      tick();
      pid_vld = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_vld", spd_vld, 0);
      check("midrst_lft", lft_spd, 0);
      check("midrst_frwrd", frwrd, 0);
      tick();
      check("midrst_vld2", spd_vld, 0);
      check("midrst_rght", rght_spd, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
